// File: rtl/pet_pkg.sv
// Shared definitions for the pet care blocks: action codes,
// executor state encoding and the action-to-frame-count mapping.
package pet_pkg;

   localparam logic [1:0] ACT_NONE  = 2'b00;
   localparam logic [1:0] ACT_FEED  = 2'b01;
   localparam logic [1:0] ACT_PLAY  = 2'b10;
   localparam logic [1:0] ACT_CLEAN = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   // Frame count of an action; ACT_NONE maps to 1 but never runs.
   function automatic logic [3:0] frames_for(
      input logic [1:0] code,
      input int         feed,
      input int         play,
      input int         clean
   );
      logic [3:0] n;
      n = 4'd1;
      case (code)
         ACT_FEED:  n = 4'(feed);
         ACT_PLAY:  n = 4'(play);
         ACT_CLEAN: n = 4'(clean);
         default:   n = 4'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pet_action_executor_timer.sv
// Animation timebase: divides clk into frames and tracks the
// current frame index of a running action.
module action_frame_timer
   import pet_pkg::*;
#(
   parameter  int TICK_DIV = 50,
   localparam int CW       = $clog2(TICK_DIV)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic       i_en,
   input  logic [3:0] i_frames,
   output logic [2:0] o_frame,
   output logic       o_frame_tick,
   output logic       o_last_frame
);

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_frame;
   logic          w_wrap;

   assign w_wrap       = (r_cnt == CW'(TICK_DIV - 1));
   assign o_frame_tick = i_en & w_wrap;
   assign o_last_frame = ({1'b0, r_frame} == (i_frames - 4'd1));
   assign o_frame      = r_frame;

   // Cycle counter and frame index; last frame wraps back to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_frame <= '0;
      end else if (i_load) begin
         r_cnt   <= '0;
         r_frame <= '0;
      end else if (i_en) begin
         if (w_wrap) begin
            r_cnt   <= '0;
            r_frame <= o_last_frame ? 3'd0 : r_frame + 3'd1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pet_action_executor.sv
// Runs a feed/play/clean action as a timed frame sequence and
// closes the controller handshake through exec_status.
module pet_action_executor
   import pet_pkg::*;
#(
   parameter int TICK_DIV     = 50,
   parameter int FEED_FRAMES  = 4,
   parameter int PLAY_FRAMES  = 6,
   parameter int CLEAN_FRAMES = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       exec,
   input  logic [1:0] selected,
   output logic       exec_status,
   output logic       busy,
   output logic [1:0] action,
   output logic [2:0] frame,
   output logic       frame_valid,
   output logic       done_pulse,
   output logic       err_pulse
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_exec_d;
   logic [1:0] r_action;
   logic [1:0] w_action_nxt;
   logic       r_fv;
   logic       r_done;
   logic       r_err;
   logic       w_fv_nxt;
   logic       w_done_nxt;
   logic       w_err_nxt;
   logic       w_load;
   logic       w_start;
   logic       w_tick;
   logic       w_last;
   logic [3:0] w_frames;

   assign w_start  = exec & ~r_exec_d;
   assign w_frames = frames_for(r_action, FEED_FRAMES,
                                PLAY_FRAMES, CLEAN_FRAMES);

   action_frame_timer #(
      .TICK_DIV(TICK_DIV)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_en        (r_state == ST_RUN),
      .i_frames    (w_frames),
      .o_frame     (frame),
      .o_frame_tick(w_tick),
      .o_last_frame(w_last)
   );

   // State, latched action, exec history and one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_exec_d <= 1'b0;
         r_action <= ACT_NONE;
         r_fv     <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_exec_d <= exec;
         r_action <= w_action_nxt;
         r_fv     <= w_fv_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // Next-state: start on exec rise, finish on last frame tick.
   always_comb begin
      w_state_nxt  = r_state;
      w_action_nxt = r_action;
      w_fv_nxt     = 1'b0;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_load       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               if (selected != ACT_NONE) begin
                  w_action_nxt = selected;
                  w_load       = 1'b1;
                  w_state_nxt  = ST_RUN;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_HOLD;
               end
            end
         end
         ST_RUN: begin
            if (w_tick) begin
               if (w_last) begin
                  w_done_nxt   = 1'b1;
                  w_action_nxt = ACT_NONE;
                  w_state_nxt  = exec ? ST_HOLD : ST_IDLE;
               end else begin
                  w_fv_nxt = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (!exec) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy        = (r_state == ST_RUN);
   assign exec_status = ~busy;
   assign action      = r_action;
   assign frame_valid = r_fv;
   assign done_pulse  = r_done;
   assign err_pulse   = r_err;

endmodule

// File: doc/pet_action_executor.md
Name: pet_action_executor

Overview:
Downstream consumer of the pet controller's `exec`/`selected` request. It runs the selected care action (feed, play or clean up) as a timed animation sequence for the display. It drives `exec_status` low while the action runs and high when it finishes, which closes the controller's execution handshake. It replaces the behavioural executor model used in system simulation with synthesizable RTL.

Parameters:
- TICK_DIV, 50, clk cycles per animation frame (50 cycles = 1 s at the 20 ms system clock); legal range ≥2.
- FEED_FRAMES, 4, frame count for action 01; legal range 1..8.
- PLAY_FRAMES, 6, frame count for action 10; legal range 1..8.
- CLEAN_FRAMES, 5, frame count for action 11; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- exec  in  1  execute request from controller; level signal, a rising edge starts an action.
- selected  in  2  action code: 00 none, 01 feed, 10 play, 11 clean.
- exec_status  out  1  1 = idle/finished, 0 = action executing.
- busy  out  1  1 while in RUN.
- action  out  2  latched action code in RUN, else 00.
- frame  out  3  current animation frame index.
- frame_valid  out  1  one-cycle pulse on each frame advance.
- done_pulse  out  1  one-cycle pulse when an action completes.
- err_pulse  out  1  one-cycle pulse when exec rises with selected = 00.

Behaviour:
- **Reset (async, any state):** state = IDLE, exec_status = 1, busy = 0, action = 00, frame = 0, cnt = 0, exec_d = 0, all pulses = 0.
- **Edge detect:** exec_d is a registered copy of exec. Start condition is exec & ~exec_d, evaluated only in IDLE.
- **States:** IDLE, RUN, HOLD.
- **IDLE, start with selected ≠ 00:** at that edge:
  - action <= selected, frame <= 0, cnt <= 0;
  - exec_status <= 0, busy <= 1;
  - go to RUN.
  - exec_status is therefore low 1 cycle after exec is first sampled high.
- **IDLE, start with selected = 00:** err_pulse <= 1, exec_status stays 1, go to HOLD.
- **RUN, each cycle:** cnt++.
- **RUN, when cnt == TICK_DIV-1:** cnt <= 0, then:
  - if frame < N-1: frame++ and frame_valid <= 1;
  - if frame == N-1 (last frame): exec_status <= 1, busy <= 0, done_pulse <= 1, action <= 00, frame <= 0; go to HOLD if exec = 1, else IDLE.
  - N is the frame count selected by the latched action.
- **RUN duration:** exactly N × TICK_DIV cycles.
- **Changes during RUN:** selected changes are ignored because action is latched. exec deasserting is also ignored; the action always completes.
- **HOLD:** wait for exec = 0, then go to IDLE. This guarantees one action per exec assertion, even though the controller holds exec high until it sees exec_status.
- **Back-to-back requests:** a new rising edge is required. exec held high across completion does not retrigger.
- **Widths:** cnt is $clog2(TICK_DIV) bits and wraps only via the explicit compare. frame is 3 bits and never exceeds N-1.
- **Pulses:** frame_valid, done_pulse and err_pulse are registered and high for exactly one cycle.
- **Reset mid-RUN:** action aborts immediately; outputs take reset values and no done_pulse is generated.

Decomposition:
- **pet_pkg:**
  - action codes ACT_NONE = 2'b00, ACT_FEED = 2'b01, ACT_PLAY = 2'b10, ACT_CLEAN = 2'b11;
  - state encoding IDLE/RUN/HOLD;
  - a function mapping action code to frame count.
  - The stats and menu blocks share the action codes.
- **Sub-module action_frame_timer** (optional):
  - holds cnt and frame, with load/enable inputs;
  - provides frame_tick and last_frame outputs.
  - The FSM stays in pet_action_executor.

Test Plan:
All scenarios use TICK_DIV = 4 and default frame counts.
1. **Feed:** selected = 01, raise exec at cycle 0 →
   - exec_status = 0 and action = 01 from cycle 1;
   - frame_valid pulses at frame 1, 2, 3;
   - exec_status = 1 and done_pulse after 16 RUN cycles;
   - state HOLD until exec dropped.
2. **Play then clean back-to-back:**
   - play → 24 RUN cycles, frame reaches 5;
   - drop exec 1 cycle, then clean → 20 RUN cycles, frame reaches 4;
   - exactly 2 done_pulses in total.
3. **selected = 00 with exec rise →** err_pulse for 1 cycle, exec_status stays 1, busy never rises; no action until exec falls and rises again.
4. **Change selected 01→11 and drop exec mid-RUN →** action stays 01, completes in 16 cycles, returns to IDLE (not HOLD).
5. **Assert rst at cycle 7 of a play action →** outputs take reset values asynchronously, with no done_pulse. After release, a fresh exec rise starts a full 24-cycle action.
6. **Hold exec high 100 cycles after a feed completes →** no second action, and exec_status stays 1 throughout.
